ice_fm_rx: RTL and testbench
============================

# ice_fm_rx

Receive-side companion of the iCE FM transmit path. Measures the instantaneous frequency of a digitised FM/IF input by counting rising edges over a fixed gate window, then converts the count to a signed 8-bit deviation about a programmable centre. Each sample is presented on a parallel strobe interface and serialised as an 8N1 UART byte for the host. Sits at the board top level between the comparator-fed RF input pin and the UART TX pin.

## Interface
- `GATE_CYCLES`, default 12000: clock cycles per measurement window (1 kHz sample rate at 12 MHz).
- `CENTER`, default 100: edge count per window that maps to deviation 0.
- `BAUD_DIV`, default 104: clock cycles per UART bit (115200 baud at 12 MHz).
- `i_clk`  in  1  system clock; the only clock in the block.
- `i_rst`  in  1  asynchronous, active-high reset.
- `i_rf`  in  1  digitised FM input; asynchronous to `i_clk`.
- `o_sample`  out  8  signed two's-complement deviation of the last completed window.
- `o_valid`  out  1  one-cycle strobe when `o_sample` updates.
- `o_tx`  out  1  UART serial output, idle high.
- `o_busy`  out  1  high while a UART frame is in progress.
- `o_ovf`  out  1  sticky flag: a sample was dropped because the UART was busy.

## Operation
- Input conditioning:
  - `i_rf` passes through a 2-flop synchroniser followed by one history flop.
  - A rising edge is synchroniser output 1 and history 0. Each qualified edge increments the edge counter by 1.
- Edge counter:
  - 16 bits, saturates at 0xFFFF with no wrap.
- Gate counter:
  - Counts 0 to GATE_CYCLES-1, then wraps to 0.
  - On the terminal cycle (value GATE_CYCLES-1), the edge counter value is captured. An edge detected in that same cycle is included in the capture.
  - The edge counter restarts at 0 on the following cycle. No edge is lost or double-counted across windows.
- Deviation:
  - diff = capture − CENTER, computed as a 17-bit signed value.
  - Saturated to the range [−128, +127] and registered into `o_sample`.
- UART transmitter FSM, with states IDLE, START, DATA, STOP:
  - IDLE: `o_tx`=1 and `o_busy`=0. On `o_valid`, latch `o_sample` into the shift register and go to START.
  - START: `o_tx`=0 for BAUD_DIV cycles.
  - DATA: 8 bits, LSB first, each held for BAUD_DIV cycles. A 3-bit bit counter advances the bit.
  - STOP: `o_tx`=1 for BAUD_DIV cycles, then return to IDLE.
  - `o_busy`=1 in START, DATA and STOP.
- Overflow:
  - If `o_valid` occurs while the FSM is not in IDLE, the new sample is not sent and the in-flight frame continues unaltered.
  - `o_ovf` is set and stays set until reset.
  - `o_sample` still updates in this case.

## Timing
- Reset values: `o_sample`=0x00, `o_valid`=0, `o_tx`=1, `o_busy`=0, `o_ovf`=0. Gate counter, edge counter, synchroniser flops and FSM state (IDLE) all clear.
- Reset is asynchronous. Asserting it mid-window or mid-frame forces every output to its reset value immediately, with no glitch low on `o_tx`. The first window after release starts at gate count 0.
- Input latency: 3 `i_clk` cycles from an `i_rf` transition to the counter increment.
- Windows are back to back with no dead cycles.
- `o_valid` and the new `o_sample` appear on the clock edge after the terminal gate cycle.
- `o_valid` is high for exactly one cycle, every GATE_CYCLES cycles.
- UART timing:
  - START begins on the clock edge after `o_valid`; `o_tx` falls and `o_busy` rises on that edge.
  - Frame length is exactly 10×BAUD_DIV cycles.
  - With the default parameters a frame (1040 cycles) is shorter than a window, so `o_ovf` never sets.
- Minimum supported input period is 4 `i_clk` cycles. Faster inputs give undefined counts but must not hang the block.

## Test plan
- Square-wave tests, default parameters:
  - `i_rf` period 120 cycles for 3 windows → each `o_valid` gives `o_sample`=0x00 (100 edges).
  - Period 100 cycles → `o_sample`=0x14 (+20), independent of input phase.
- Saturation:
  - `i_rf` held low → `o_sample`=0x9C (−100).
  - Period 40 cycles (300 edges, +200) → `o_sample`=0x7F.
- UART frame for sample 0x14:
  - `o_tx` = 0 (start), then 0,0,1,0,1,0,0,0, then 1 (stop), each held exactly 104 cycles.
  - `o_busy` high for exactly 1040 cycles, then `o_tx` idles high.
- Overflow with GATE_CYCLES=500: the second `o_valid` arrives during frame 1 → `o_ovf`=1 and stays 1. Frame 1 bits are unchanged, and the dropped sample is never transmitted.
- Reset mid-frame: assert `i_rst` during DATA bit 3 → `o_tx`=1, `o_busy`=0, `o_ovf`=0 and `o_sample`=0x00 immediately. After release, the first `o_valid` occurs exactly GATE_CYCLES+1 cycles later.

Source files
------------

// File: rtl/ice_fm_rx.sv
// ice_fm_rx -- FM receive front end.
//   Counts rising edges of the asynchronous i_rf input over a fixed gate
//   window, converts the count to a saturated signed deviation about CENTER
//   and ships each sample to the host as an 8N1 UART byte.
// Ports:
//   i_clk     system clock (only clock domain)
//   i_rst     asynchronous active-high reset
//   i_rf      digitised FM input, asynchronous to i_clk
//   o_sample  signed 8-bit deviation of the last completed window
//   o_valid   one-cycle strobe when o_sample updates
//   o_tx      UART serial output, idle high
//   o_busy    high while a UART frame is in progress
//   o_ovf     sticky: a sample was dropped because the UART was busy
module ice_fm_rx #(
    parameter int unsigned GATE_CYCLES = 12000,
    parameter int unsigned CENTER      = 100,
    parameter int unsigned BAUD_DIV    = 104
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rf,
    output logic [7:0] o_sample,
    output logic       o_valid,
    output logic       o_tx,
    output logic       o_busy,
    output logic       o_ovf
);

    localparam int unsigned GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam int unsigned BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    // Input conditioning and measurement
    logic               sync1_q, sync2_q, hist_q;
    logic               rise;
    logic [GW-1:0]      gate_q, gate_d;
    logic               terminal;
    logic [15:0]        edge_q, edge_d, edge_inc;
    logic signed [16:0] diff;
    logic [7:0]         sat;
    logic [7:0]         sample_q, sample_d;
    logic               valid_q, valid_d;

    // UART transmitter
    state_t             state_q, state_d;
    logic [BW-1:0]      baud_q, baud_d;
    logic [2:0]         bit_q, bit_d;
    logic [7:0]         shift_q, shift_d;
    logic               tx_q, tx_d;
    logic               busy_q, busy_d;
    logic               ovf_q, ovf_d;
    logic               baud_last;

    assign rise     = sync2_q & ~hist_q;
    assign terminal = (gate_q == GW'(GATE_CYCLES - 1));

    always_comb begin
        edge_inc = edge_q;
        if (rise && (edge_q != 16'hFFFF)) begin
            edge_inc = edge_q + 16'd1;
        end
        // Capture uses edge_inc so an edge landing on the terminal cycle is
        // counted in this window, while the counter restarts from zero next.
        gate_d   = terminal ? '0 : gate_q + GW'(1);
        edge_d   = terminal ? '0 : edge_inc;
        diff     = $signed({1'b0, edge_inc}) - $signed(17'(CENTER));
        if (diff > 17'sd127) begin
            sat = 8'h7F;
        end else if (diff < -17'sd128) begin
            sat = 8'h80;
        end else begin
            sat = diff[7:0];
        end
        sample_d = terminal ? sat : sample_q;
        valid_d  = terminal;
    end

    assign baud_last = (baud_q == BW'(BAUD_DIV - 1));

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        ovf_d   = ovf_q | (valid_q && (state_q != S_IDLE));
        case (state_q)
            S_IDLE: begin
                if (valid_q) begin
                    state_d = S_START;
                    shift_d = sample_q;
                    baud_d  = '0;
                end
            end
            S_START: begin
                if (baud_last) begin
                    state_d = S_DATA;
                    baud_d  = '0;
                    bit_d   = '0;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            S_DATA: begin
                if (baud_last) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            S_STOP: begin
                if (baud_last) begin
                    state_d = S_IDLE;
                    baud_d  = '0;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Line and busy are registered from the next state so o_tx cannot
        // glitch while the state encoding changes.
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            hist_q   <= 1'b0;
            gate_q   <= '0;
            edge_q   <= '0;
            sample_q <= '0;
            valid_q  <= 1'b0;
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            sync1_q  <= i_rf;
            sync2_q  <= sync1_q;
            hist_q   <= sync2_q;
            gate_q   <= gate_d;
            edge_q   <= edge_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            ovf_q    <= ovf_d;
        end
    end

    assign o_sample = sample_q;
    assign o_valid  = valid_q;
    assign o_tx     = tx_q;
    assign o_busy   = busy_q;
    assign o_ovf    = ovf_q;

endmodule

// File: tb/tb_ice_fm_rx.sv
// tb_ice_fm_rx -- self-checking bench for ice_fm_rx.
//   Four default-parameter instances run square waves of different periods in
//   parallel (one vector-table row each); a fifth instance with a 500-cycle
//   gate exercises UART overflow. A per-cycle frame model checks every bit
//   slot of every transmitted frame, then a reset is forced mid-frame.
module tb_ice_fm_rx;

    localparam int unsigned NI   = 5;
    localparam int unsigned BAUD = 104;

    typedef struct {
        int unsigned period;   // 0 = input held low
        int unsigned phase;
        int unsigned gate;
        logic [7:0]  exp;
    } vec_t;

    vec_t        tbl [NI];

    logic        clk;
    logic        rst;
    logic        rf_w     [NI];
    logic [7:0]  sample_w [NI];
    logic        valid_w  [NI];
    logic        tx_w     [NI];
    logic        busy_w   [NI];
    logic        ovf_w    [NI];

    int          checks;
    int          failures;
    int unsigned cyc;
    int unsigned tcnt;
    bit          post_rst2;

    // Frame / timing model state
    bit          m_active   [NI];
    int unsigned m_off      [NI];
    logic [7:0]  m_data     [NI];
    bit          m_ovf      [NI];
    bit          slot_ok    [NI];
    bit          idle_ok    [NI];
    bit          first_seen [NI];
    int unsigned last_v     [NI];
    int unsigned nvalid     [NI];

    for (genvar g = 0; g < 4; g++) begin : g_def
        ice_fm_rx u_dut (
            .i_clk    (clk),
            .i_rst    (rst),
            .i_rf     (rf_w[g]),
            .o_sample (sample_w[g]),
            .o_valid  (valid_w[g]),
            .o_tx     (tx_w[g]),
            .o_busy   (busy_w[g]),
            .o_ovf    (ovf_w[g])
        );
    end

    ice_fm_rx #(.GATE_CYCLES(500)) u_ovf (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_rf     (rf_w[4]),
        .o_sample (sample_w[4]),
        .o_valid  (valid_w[4]),
        .o_tx     (tx_w[4]),
        .o_busy   (busy_w[4]),
        .o_ovf    (ovf_w[4])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int k, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s inst=%0d got=%0d want=%0d (cyc=%0d)", nm, k, act, exp, cyc);
        end
    endtask

    function automatic logic exp_tx(input int k, input int unsigned off);
        int unsigned slot;
        slot = off / BAUD;
        if (slot == 0) return 1'b0;
        if (slot == 9) return 1'b1;
        return m_data[k][slot-1];
    endfunction

    task automatic monitor();
        for (int k = 0; k < NI; k++) begin
            bit en;
            bit was;
            en = !post_rst2 || (k == 2) || (k == 3);
            if (rst) begin
                m_active[k] = 0;
                m_off[k]    = 0;
                m_ovf[k]    = 0;
                slot_ok[k]  = 1;
                idle_ok[k]  = 1;
                continue;
            end
            was = m_active[k];
            if (en) begin
                if (was) begin
                    if (tx_w[k] !== exp_tx(k, m_off[k]) || busy_w[k] !== 1'b1) slot_ok[k] = 0;
                    if (m_off[k] % BAUD == BAUD - 1) begin
                        chk($sformatf("uart_slot%0d", m_off[k] / BAUD), k, slot_ok[k], 1);
                        slot_ok[k] = 1;
                    end
                    m_off[k]++;
                    if (m_off[k] == 10 * BAUD) m_active[k] = 0;
                end else if (tx_w[k] !== 1'b1 || busy_w[k] !== 1'b0) begin
                    idle_ok[k] = 0;
                end
            end
            if (valid_w[k] === 1'b1) begin
                nvalid[k]++;
                if (!first_seen[k]) chk("first_valid_cycle", k, cyc, tbl[k].gate + 1);
                else                chk("valid_period", k, cyc - last_v[k], tbl[k].gate);
                first_seen[k] = 1;
                last_v[k]     = cyc;
                if (en) begin
                    chk("sample", k, sample_w[k], tbl[k].exp);
                    chk("ovf_at_valid", k, ovf_w[k], m_ovf[k]);
                    if (!was) begin
                        chk("uart_idle", k, idle_ok[k], 1);
                        idle_ok[k]  = 1;
                        m_active[k] = 1;
                        m_off[k]    = 0;
                        m_data[k]   = tbl[k].exp;
                    end else begin
                        m_ovf[k] = 1;
                    end
                end
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        monitor();
        for (int k = 0; k < NI; k++) begin
            if (tbl[k].period == 0) rf_w[k] = 1'b0;
            else rf_w[k] = ((tcnt + tbl[k].phase) % tbl[k].period) < (tbl[k].period / 2);
        end
        tcnt++;
    endtask

    initial begin
        bit got;
        tbl[0] = '{period: 120, phase: 0,  gate: 12000, exp: 8'h00};
        tbl[1] = '{period: 100, phase: 73, gate: 12000, exp: 8'h14};
        tbl[2] = '{period: 0,   phase: 0,  gate: 12000, exp: 8'h9C};
        tbl[3] = '{period: 40,  phase: 0,  gate: 12000, exp: 8'h7F};
        tbl[4] = '{period: 20,  phase: 0,  gate: 500,   exp: 8'hB5};
        checks    = 0;
        failures  = 0;
        cyc       = 0;
        tcnt      = 0;
        post_rst2 = 0;
        rst       = 1'b1;
        for (int k = 0; k < NI; k++) begin
            rf_w[k]       = 1'b0;
            first_seen[k] = 0;
            nvalid[k]     = 0;
            last_v[k]     = 0;
            m_active[k]   = 0;
            m_off[k]      = 0;
            m_ovf[k]      = 0;
            m_data[k]     = '0;
            slot_ok[k]    = 1;
            idle_ok[k]    = 1;
        end

        repeat (3) @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            chk("rst_sample", k, sample_w[k], 0);
            chk("rst_valid",  k, valid_w[k],  0);
            chk("rst_tx",     k, tx_w[k],     1);
            chk("rst_busy",   k, busy_w[k],   0);
            chk("rst_ovf",    k, ovf_w[k],    0);
        end

        @(posedge clk);
        #1 rst = 1'b0;
        cyc = 0;

        got = 0;
        for (int i = 0; i < 40000 && !got; i++) begin
            step();
            if (nvalid[1] == 3) got = 1;
        end
        chk("wait_third_valid", 1, got, 1);

        // Third frame of instance 1 (0x14): land inside DATA bit 3 (a 0 bit).
        repeat (461) step();
        chk("tx_before_rst",   1, tx_w[1],   0);
        chk("busy_before_rst", 1, busy_w[1], 1);
        chk("ovf_sticky",      4, ovf_w[4],  1);

        #2 rst = 1'b1;
        #1;
        for (int k = 0; k < NI; k++) begin
            chk("async_rst_sample", k, sample_w[k], 0);
            chk("async_rst_valid",  k, valid_w[k],  0);
            chk("async_rst_tx",     k, tx_w[k],     1);
            chk("async_rst_busy",   k, busy_w[k],   0);
            chk("async_rst_ovf",    k, ovf_w[k],    0);
        end
        repeat (4) step();

        @(posedge clk);
        #1 rst = 1'b0;
        cyc       = 0;
        post_rst2 = 1;
        for (int k = 0; k < NI; k++) first_seen[k] = 0;
        repeat (12100) step();

        for (int k = 0; k < NI; k++) chk("valid_after_release", k, first_seen[k], 1);
        chk("final_idle", 2, idle_ok[2], 1);
        chk("final_idle", 3, idle_ok[3], 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
